f2i_seq: RTL and testbench



---
 rtl/f2i_seq_if.sv | 25 ++
 rtl/f2i_seq.sv | 139 +++++++++++++
 tb/tb_f2i_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/f2i_seq_if.sv
// Operand/result handshake bundle for the float-to-int converter.
// No logic; carries the in/out valid-ready pairs plus operand, result and flags.
// Backpressure: out_ready from the consumer, in_ready from the converter.
interface f2i_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        p_lost;
    logic        invalid;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, d, p_lost, invalid
    );

    // The converter itself
    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, d, p_lost, invalid
    );
endinterface

// File: rtl/f2i_seq.sv
// Float32 -> int32 converter, 5-stage sequential barrel shift, sign and saturation.
// Latency: 6 edges from accept to out_valid; at most one result per 8 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Macro F2I_RNE_EN selects round-to-nearest-even.
module f2i_seq (
    input  logic      clk,
    input  logic      rst,
    f2i_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

    state_t      st_q, st_nxt;
    logic [2:0]  k_q;
    logic [31:0] m_q;
    logic [4:0]  sa_q;
    logic        sign_q, inv_q, nan_q, sticky_q;
`ifdef F2I_RNE_EN
    logic        guard_q;
`endif
    logic [31:0] d_q;
    logic        p_lost_q, invalid_q;

    // Operand classification at capture
    logic [7:0]  e_in;
    logic [22:0] frac_in;
    logic        cap_nan, cap_inv, cap_norm, cap_small;
    assign e_in      = bus.a[30:23];
    assign frac_in   = bus.a[22:0];
    assign cap_nan   = (e_in == 8'hFF) && (|frac_in);
    // e>=158 overflows int32, except exactly -2^31
    assign cap_inv   = (e_in == 8'hFF) || ((e_in >= 8'd158) && (bus.a != 32'hCF00_0000));
    assign cap_norm  = !cap_inv && (e_in >= 8'd127);
    assign cap_small = (e_in != 8'd0) && (e_in < 8'd127);

    // One shift stage of width 2^k, plus the bits it discards
    logic [4:0]  sh_n;
    logic [31:0] lo_mask, m_shr;
    assign sh_n    = 5'd1 << k_q;
    assign lo_mask = (32'd1 << sh_n) - 32'd1;
    assign m_shr   = m_q >> sh_n;
`ifdef F2I_RNE_EN
    logic        g_bit, g_rest;
    assign g_bit  = |(m_q & (32'd1 << (sh_n - 5'd1)));
    assign g_rest = |(m_q & ((32'd1 << (sh_n - 5'd1)) - 32'd1));
`endif

    // Final magnitude, sign application and saturation
    logic [31:0] mag, res;
    logic        lost;
`ifdef F2I_RNE_EN
    assign mag  = m_q + {31'd0, guard_q & (sticky_q | m_q[0])};
    assign lost = guard_q | sticky_q;
`else
    assign mag  = m_q;
    assign lost = sticky_q;
`endif
    assign res = inv_q ? ((nan_q || !sign_q) ? 32'h7FFF_FFFF : 32'h8000_0000)
                       : (sign_q ? (~mag + 32'd1) : mag);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_nxt;
    end

    // Next-state decode
    always_comb begin
        st_nxt = st_q;
        case (st_q)
            IDLE:    if (bus.in_valid) st_nxt = SHIFT;
            SHIFT:   if (k_q == 3'd0) st_nxt = NEG;
            NEG:     st_nxt = DONE;
            DONE:    if (bus.out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Datapath: capture, shift stages, result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= 3'd0;
            m_q       <= 32'd0;
            sa_q      <= 5'd0;
            sign_q    <= 1'b0;
            inv_q     <= 1'b0;
            nan_q     <= 1'b0;
            sticky_q  <= 1'b0;
`ifdef F2I_RNE_EN
            guard_q   <= 1'b0;
`endif
            d_q       <= 32'd0;
            p_lost_q  <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE: if (bus.in_valid) begin
                    k_q    <= 3'd4;
                    sign_q <= bus.a[31];
                    inv_q  <= cap_inv;
                    nan_q  <= cap_nan;
                    m_q    <= cap_norm ? {1'b1, frac_in, 8'h00} : 32'd0;
                    // 158 - e modulo 32; exact for 127 <= e <= 158
                    sa_q   <= cap_norm ? (5'd30 - e_in[4:0]) : 5'd0;
`ifdef F2I_RNE_EN
                    // Sub-unity values: 0.5 bit is the guard, the rest is sticky
                    guard_q  <= (e_in == 8'd126);
                    sticky_q <= (e_in == 8'd0)   ? (|frac_in) :
                                (e_in == 8'd126) ? (|frac_in) : cap_small;
`else
                    sticky_q <= (e_in == 8'd0) ? (|frac_in) : cap_small;
`endif
                end
                SHIFT: begin
                    if (sa_q[k_q]) begin
                        m_q <= m_shr;
`ifdef F2I_RNE_EN
                        guard_q  <= g_bit;
                        sticky_q <= sticky_q | guard_q | g_rest;
`else
                        sticky_q <= sticky_q | (|(m_q & lo_mask));
`endif
                    end
                    if (k_q != 3'd0) k_q <= k_q - 3'd1;
                end
                NEG: begin
                    d_q       <= res;
                    p_lost_q  <= inv_q ? 1'b0 : lost;
                    invalid_q <= inv_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (st_q == IDLE);
    assign bus.out_valid = (st_q == DONE);
    assign bus.d         = d_q;
    assign bus.p_lost    = p_lost_q;
    assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_f2i_seq.sv
// Bench for f2i_seq: directed edge cases, handshake timing, reset abort, random operands.
// Reference is an arithmetic model of float->int (exact scaling, range check, rounding).
// Backpressure exercised by holding out_ready low in DONE.
module tb_f2i_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    f2i_seq_if bus ();
    f2i_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: value = M * 2^-sh, then round, range-check, apply sign
    function automatic logic [33:0] ref_f2i(input logic [31:0] x);
        logic              s;
        int                e, sh;
        longint unsigned   mm, mag, rem;
        logic              lost;
        logic [31:0]       r;
        s = x[31];
        e = int'(x[30:23]);
        if (e == 255)
            return {((x[22:0] != 0) || !s) ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        if (e == 0) begin mm = 64'(x[22:0]); sh = 149; end
        else begin mm = 64'({1'b1, x[22:0]}); sh = 150 - e; end
        rem = 0;
        if (sh < -30)      mag = 64'h1_0000_0000;
        else if (sh <= 0)  mag = mm << (-sh);
        else if (sh > 40)  begin mag = 0; rem = mm; end
        else begin
            mag = mm >> sh;
            rem = mm & ((64'd1 << sh) - 64'd1);
        end
        lost = (rem != 0);
`ifdef F2I_RNE_EN
        if (sh > 0 && sh <= 40) begin
            if (rem > (64'd1 << (sh - 1)) || (rem == (64'd1 << (sh - 1)) && mag[0]))
                mag = mag + 1;
        end
`endif
        if (mag > 64'h7FFF_FFFF && !(s && mag == 64'h8000_0000))
            return {s ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1};
        r = s ? (32'd0 - mag[31:0]) : mag[31:0];
        return {r, lost, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One conversion: accept, measure latency, check result, hold, release
    task automatic do_op(input logic [31:0] av, input int hold, input bit poke);
        logic [33:0] ex;
        int n;
        ex = ref_f2i(av);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a = av;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = $urandom;
        if (!poke) bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            if (poke) bus.a = $urandom;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 32'(n), 32'd6);
        chk("d", bus.d, ex[33:2]);
        chk("p_lost", 32'(bus.p_lost), 32'(ex[1]));
        chk("invalid", 32'(bus.invalid), 32'(ex[0]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_d", bus.d, ex[33:2]);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  re;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_d", bus.d, 32'd0);
        chk("rst_p_lost", 32'(bus.p_lost), 32'd0);
        chk("rst_invalid", 32'(bus.invalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(32'h3FC0_0000, 0, 1'b0);
        do_op(32'hC2F7_0000, 0, 1'b0);
        do_op(32'hCF00_0000, 0, 1'b0);
        do_op(32'h4F00_0000, 0, 1'b0);
        do_op(32'h7FC0_0000, 0, 1'b0);
        do_op(32'hFF80_0000, 0, 1'b0);
        do_op(32'h0000_0001, 0, 1'b0);
        do_op(32'h8000_0000, 0, 1'b0);
        do_op(32'h3F00_0000, 0, 1'b0);
        do_op(32'h3F40_0000, 0, 1'b0);
        do_op(32'hBF40_0000, 0, 1'b0);
        do_op(32'h4EFF_FFFF, 0, 1'b0);
        do_op(32'hCF00_0001, 0, 1'b0);
        do_op(32'h3F80_0000, 0, 1'b0);
        do_op(32'h4B00_0001, 0, 1'b0);

        // Backpressure: result held 10 cycles
        do_op(32'h4700_0000, 10, 1'b0);

        // in_valid pulses while busy are neither converted nor queued
        do_op(32'h4148_0000, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_queued_result", 32'(bus.out_valid), 32'd0);
        end

        // Reset during SHIFT aborts immediately
        @(negedge clk);
        bus.a = 32'h4B12_3456;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_d", bus.d, 32'd0);
        chk("mid_rst_p_lost", 32'(bus.p_lost), 32'd0);
        chk("mid_rst_invalid", 32'(bus.invalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("aborted_no_result", 32'(bus.out_valid), 32'd0);
        end
        do_op(32'h4228_0000, 0, 1'b0);

        // Random operands, biased toward the interesting exponent range
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0, 1: re = 8'($urandom_range(100, 160));
                2:    re = 8'($urandom_range(122, 133));
                default: re = ra[30:23];
            endcase
            ra[30:23] = re;
            do_op(ra, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
